// File: rtl/instr_fetch_pkg.sv
// riscv_pkg: shared definitions for the fetch stage.
//   XLEN          - address / instruction width
//   OPC_*         - RV32I major opcodes seen on if_opcode by the control unit
//   fetch_state_e - fetch FSM encoding (BOOT / RUN / DRAIN)
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the fetch stage's memory, redirect and decode
// handshakes.
//   master modport - the fetch stage (drives requests and the decode head)
//   slave modport  - the environment (memory, branch unit, decode)
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [6:0]      if_opcode;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_opcode,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
               redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_opcode,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
               redirect_pc, if_ready
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of DEPTH entries, WIDTH bits each, holding
// {pc, instruction} pairs for decode. Registered storage, no bypass.
//   push/wdata - write an entry (honoured when full if pop in same cycle)
//   pop/rdata  - remove the head; rdata reads 0 while empty
//   flush      - discard all entries (wins over push and pop)
//   count/full/empty - occupancy status
// fetch_fifo_chk: overflow checker instantiated by the fetch top.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] PINC_C  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {CW{1'b0}});
    assign full      = (count_r == DEPTH_C);
    assign count     = count_r;
    assign do_pop_s  = pop && !empty;
    // A full buffer still accepts a push when the head leaves the same cycle.
    assign do_push_s = push && (!full || do_pop_s);

    // Head read-out, forced to zero while empty so idle outputs are clean.
    always_comb begin
        rdata = {WIDTH{1'b0}};
        if (!empty) begin
            rdata = mem_r[rd_ptr_r];
        end else begin
            rdata = {WIDTH{1'b0}};
        end
    end

    // Occupancy update from the accepted push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers and count; flush drops everything but keeps data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PINC_C;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PINC_C;
            end
            count_r <= count_next_s;
        end
    end
endmodule

module fetch_fifo_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic full
);
    // The credit scheme must never let a response land in a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
        else $error("fetch_fifo: push into full buffer without pop");
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RISC-V instruction fetch stage.
// Owns the PC, issues word fetches while credits allow (outstanding requests
// plus buffered instructions < DEPTH), buffers returned words with their PC
// and presents them to decode. A redirect flushes the buffer, reloads the PC
// and counts the still-outstanding responses that must be discarded.
//   clk, rst - clock and asynchronous active-high reset
//   bus      - instr_fetch_if master: imem request/response, redirect,
//              decode head (if_valid/if_ready/if_instr/if_pc/if_opcode)
module instr_fetch #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);
    import riscv_pkg::*;

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP_C  = XLEN'(4);

    fetch_state_e    state_r;
    fetch_state_e    state_next_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic [XLEN-1:0] rsp_pc_r;
    logic [XLEN-1:0] rsp_pc_next_s;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   outstanding_next_s;
    logic [CW-1:0]   drop_cnt_r;
    logic [CW-1:0]   drop_cnt_next_s;
    logic [CW-1:0]   fifo_count_s;
    logic [CW-1:0]   rsp_dec_s;
    logic [CW:0]     inflight_s;
    logic [XLEN-1:0] target_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            push_s;
    logic            pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [2*XLEN-1:0] head_s;

    assign target_s    = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign inflight_s  = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
    assign req_valid_s = (state_r != ST_BOOT) && (inflight_s < DEPTH_C) && !bus.redirect_valid;
    assign req_fire_s  = req_valid_s && bus.imem_req_ready;
    assign rsp_dec_s   = {{(CW-1){1'b0}}, bus.imem_rsp_valid};
    // Responses are kept only outside a redirect cycle and with nothing left to drop.
    assign push_s      = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt_r == {CW{1'b0}});
    assign pop_s       = !fifo_empty_s && bus.if_ready;

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_r;
    assign bus.if_valid       = !fifo_empty_s;
    assign bus.if_pc          = head_s[2*XLEN-1:XLEN];
    assign bus.if_instr       = head_s[XLEN-1:0];
    assign bus.if_opcode      = head_s[6:0];

    // Next values of the PCs and the request/drop counters.
    always_comb begin
        pc_next_s          = pc_r;
        rsp_pc_next_s      = rsp_pc_r;
        outstanding_next_s = outstanding_r;
        drop_cnt_next_s    = drop_cnt_r;
        if (bus.redirect_valid) begin
            pc_next_s     = target_s;
            rsp_pc_next_s = target_s;
            // Every in-flight response not arriving right now is wrong-path.
            drop_cnt_next_s = outstanding_r - rsp_dec_s;
        end else begin
            if (req_fire_s) begin
                pc_next_s = pc_r + STEP_C;
            end else begin
                pc_next_s = pc_r;
            end
            if (push_s) begin
                rsp_pc_next_s = rsp_pc_r + STEP_C;
            end else begin
                rsp_pc_next_s = rsp_pc_r;
            end
            if (bus.imem_rsp_valid && (drop_cnt_r != {CW{1'b0}})) begin
                drop_cnt_next_s = drop_cnt_r - ONE_C;
            end else begin
                drop_cnt_next_s = drop_cnt_r;
            end
        end
        case ({req_fire_s, bus.imem_rsp_valid})
            2'b10:   outstanding_next_s = outstanding_r + ONE_C;
            2'b01:   outstanding_next_s = outstanding_r - ONE_C;
            default: outstanding_next_s = outstanding_r;
        endcase
    end

    // Fetch FSM next state: BOOT lasts one cycle, then RUN/DRAIN follow drop_cnt.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: state_next_s = ST_RUN;
            ST_RUN, ST_DRAIN: begin
                if (drop_cnt_next_s != {CW{1'b0}}) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_BOOT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
        end else begin
            pc_r          <= pc_next_s;
            rsp_pc_r      <= rsp_pc_next_s;
            outstanding_r <= outstanding_next_s;
            drop_cnt_r    <= drop_cnt_next_s;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (bus.redirect_valid),
        .wdata ({rsp_pc_r, bus.imem_rsp_data}),
        .rdata (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    fetch_fifo_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .pop  (pop_s),
        .full (fifo_full_s)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: an in-order memory model with configurable
// latency/readiness answers fetches; a monitor checks every request address
// and every delivered {pc, instruction} against the architectural stream
// (sequential PCs from the last redirect target or RESET_PC).
module tb_instr_fetch;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Memory model knobs and bench-side bookkeeping.
    int          ready_pct = 100;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          last_due  = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] fire_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_req;

    instr_fetch_if #(.XLEN(32)) bus ();

    instr_fetch #(
        .XLEN     (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory contents: unique per address, opcode cycles by word.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        logic [6:0] opc;
        case (a[3:2])
            2'd0:    opc = 7'b0010011;
            2'd1:    opc = 7'b0110011;
            2'd2:    opc = 7'b1100011;
            default: opc = 7'b1101111;
        endcase
        return (a << 5) | {25'd0, opc};
    endfunction

    // Memory responder: in-order responses, at most one per cycle.
    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.imem_req_ready = 1'b0;
                bus.imem_rsp_valid = 1'b0;
            end else begin
                bus.imem_req_ready = (int'($urandom_range(0, 99)) < ready_pct);
                if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mdata(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    bus.imem_rsp_valid = 1'b0;
                    bus.imem_rsp_data  = $urandom;
                end
            end
        end
    end

    // Monitor: checks handshakes against the expected fetch stream.
    initial begin
        logic [31:0] ed;
        int          due;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.if_valid && bus.if_ready) begin
                    ed = mdata(exp_pc);
                    n_checks++;
                    if (bus.if_pc !== exp_pc || bus.if_instr !== ed || bus.if_opcode !== ed[6:0]) begin
                        n_fail++;
                        $display("FAIL pop_stream: got pc=%h instr=%h opc=%b, want pc=%h instr=%h opc=%b",
                                 bus.if_pc, bus.if_instr, bus.if_opcode, exp_pc, ed, ed[6:0]);
                    end
                    pop_log.push_back(bus.if_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                if (bus.redirect_valid) begin
                    n_checks++;
                    if (bus.imem_req_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL redirect_no_req: req_valid=%b, want 0", bus.imem_req_valid);
                    end
                    exp_pc  = {bus.redirect_pc[31:2], 2'b00};
                    exp_req = {bus.redirect_pc[31:2], 2'b00};
                end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                    n_checks++;
                    if (bus.imem_req_addr !== exp_req) begin
                        n_fail++;
                        $display("FAIL req_addr: got %h, want %h", bus.imem_req_addr, exp_req);
                    end
                    fire_log.push_back(bus.imem_req_addr);
                    pend_addr.push_back(bus.imem_req_addr);
                    due = cyc + int'($urandom_range(lat_min, lat_max));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend_due.push_back(due);
                    exp_req = exp_req + 32'd4;
                    n_checks++;
                    if (pend_addr.size() > DEPTH) begin
                        n_fail++;
                        $display("FAIL credit: outstanding=%0d, limit %0d", pend_addr.size(), DEPTH);
                    end
                end
            end
        end
    end

    task automatic reset_on(input int rdy, input int lmin, input int lmax, input logic ifr);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = ifr;
        ready_pct = rdy;
        lat_min   = lmin;
        lat_max   = lmax;
        last_due  = 0;
        pend_addr.delete();
        pend_due.delete();
        fire_log.delete();
        pop_log.delete();
        exp_pc  = RESET_PC;
        exp_req = RESET_PC;
    endtask

    task automatic reset_off();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_on(100, 1, 1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== RESET_PC || bus.if_valid !== 1'b0 ||
            bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0 || bus.if_opcode !== 7'h0) begin
            n_fail++;
            $display("FAIL reset_values: rv=%b ra=%h iv=%b ii=%h ip=%h io=%b, want 0 %h 0 0 0 0",
                     bus.imem_req_valid, bus.imem_req_addr, bus.if_valid, bus.if_instr, bus.if_pc,
                     bus.if_opcode, RESET_PC);
        end
        reset_off();
        @(negedge clk);
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_cycle: req_valid=%b, want 0", bus.imem_req_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req: valid=%b addr=%h, want 1 00000000", bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: if_valid=%b, want 0", bus.if_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_opcode !== 7'b0010011 || bus.if_instr !== 32'h13) begin
            n_fail++;
            $display("FAIL first_instr: v=%b pc=%h opc=%b instr=%h, want 1 00000000 0010011 00000013",
                     bus.if_valid, bus.if_pc, bus.if_opcode, bus.if_instr);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (fire_log.size() < 3) begin
            n_fail++;
            $display("FAIL seq_addr: only %0d requests, want >=3", fire_log.size());
        end else if (fire_log[1] !== 32'h4 || fire_log[2] !== 32'h8) begin
            n_fail++;
            $display("FAIL seq_addr: got %h %h, want 00000004 00000008", fire_log[1], fire_log[2]);
        end
    endtask

    task automatic test_backpressure();
        reset_on(100, 1, 1, 1'b0);
        reset_off();
        repeat (7) @(negedge clk);
        n_checks++;
        if (fire_log.size() != DEPTH) begin
            n_fail++;
            $display("FAIL bp_requests: %0d issued, want %0d", fire_log.size(), DEPTH);
        end
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_head: v=%b pc=%h, want 1 00000000", bus.if_valid, bus.if_pc);
        end
        @(posedge clk);
        #1;
        bus.if_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (pop_log.size() < 2) begin
            n_fail++;
            $display("FAIL bp_release: %0d pops, want >=2", pop_log.size());
        end else if (pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4) begin
            n_fail++;
            $display("FAIL bp_release: pcs %h %h, want 00000000 00000004", pop_log[0], pop_log[1]);
        end
    endtask

    task automatic test_redirect();
        reset_on(100, 4, 4, 1'b1);
        reset_off();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (pend_addr.size() != 2) begin
            n_fail++;
            $display("FAIL rd_outstanding: %0d, want 2", pend_addr.size());
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.if_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_flush: if_valid=%b at cycle %0d after redirect, want 0", bus.if_valid, i + 1);
            end
        end
        for (int i = 0; i < 50 && pop_log.size() == 0; i++) @(negedge clk);
        n_checks++;
        if (pop_log.size() == 0) begin
            n_fail++;
            $display("FAIL rd_target: timeout waiting for pop, want pc 00000100");
        end else if (pop_log[0] !== 32'h100) begin
            n_fail++;
            $display("FAIL rd_target: first pc %h, want 00000100", pop_log[0]);
        end
    endtask

    task automatic test_redirect_rsp();
        reset_on(100, 2, 2, 1'b1);
        reset_off();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // The response to address 0 is due in this very cycle.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0203;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL rr_req: valid=%b addr=%h, want 1 00000200", bus.imem_req_valid, bus.imem_req_addr);
        end
        for (int i = 0; i < 50 && pop_log.size() == 0; i++) @(negedge clk);
        n_checks++;
        if (pop_log.size() == 0) begin
            n_fail++;
            $display("FAIL rr_target: timeout waiting for pop, want pc 00000200");
        end else if (pop_log[0] !== 32'h200) begin
            n_fail++;
            $display("FAIL rr_target: first pc %h, want 00000200", pop_log[0]);
        end
    endtask

    task automatic test_wrap();
        reset_on(100, 1, 1, 1'b1);
        reset_off();
        repeat (4) @(posedge clk);
        #1;
        fire_log.delete();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (fire_log.size() < 2) begin
            n_fail++;
            $display("FAIL wrap: %0d requests after redirect, want >=2", fire_log.size());
        end else if (fire_log[0] !== 32'hFFFF_FFFC || fire_log[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap: addrs %h %h, want fffffffc 00000000", fire_log[0], fire_log[1]);
        end
    endtask

    task automatic test_random();
        logic prev_rd;
        reset_on(70, 1, 3, 1'b1);
        reset_off();
        prev_rd = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            bus.if_ready = ($urandom_range(0, 3) != 0);
            if (!prev_rd && $urandom_range(0, 31) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = $urandom;
            end else begin
                bus.redirect_valid = 1'b0;
            end
            prev_rd = bus.redirect_valid;
        end
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (pop_log.size() < 100) begin
            n_fail++;
            $display("FAIL random_progress: %0d pops, want >=100", pop_log.size());
        end
    endtask

    task automatic test_async_reset();
        reset_on(100, 1, 2, 1'b1);
        reset_off();
        repeat (6) @(posedge clk);
        #1;
        bus.if_ready = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset_on(100, 1, 1, 1'b1);
        #1;
        n_checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== RESET_PC || bus.if_valid !== 1'b0 ||
            bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0 || bus.if_opcode !== 7'h0) begin
            n_fail++;
            $display("FAIL async_reset: rv=%b ra=%h iv=%b ii=%h ip=%h io=%b, want 0 %h 0 0 0 0",
                     bus.imem_req_valid, bus.imem_req_addr, bus.if_valid, bus.if_instr, bus.if_pc,
                     bus.if_opcode, RESET_PC);
        end
        repeat (2) @(posedge clk);
        reset_off();
        repeat (6) @(negedge clk);
        n_checks++;
        if (fire_log.size() == 0) begin
            n_fail++;
            $display("FAIL restart: no request after reset, want %h", RESET_PC);
        end else if (fire_log[0] !== RESET_PC) begin
            n_fail++;
            $display("FAIL restart: first addr %h, want %h", fire_log[0], RESET_PC);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        exp_pc  = RESET_PC;
        exp_req = RESET_PC;
        test_reset();
        test_backpressure();
        test_redirect();
        test_redirect_rsp();
        test_wrap();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
